mem_port_ctrl: RTL and testbench

Request front-end that sits directly upstream of the 1024×32 asynchronous-read data memory and owns its write and read ports. Read and write commands arrive on a valid/ready request channel and are buffered in a small in-order FIFO. Each command is issued to the memory for exactly one cycle, and the result returns on a valid/ready response channel. This serialises all memory traffic, guarantees read-after-write ordering and keeps the memory's combinational read path off every downstream timing path.

---
 rtl/mem_ctrl_pkg.sv | 30 +++
 rtl/mem_req_fifo.sv | 53 +++++
 rtl/mem_port_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_port_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory port controller: FSM states,
// the buffered command record and the address range helper.
package mem_ctrl_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int DEPTH       = 1024;
    localparam int FIFO_DEPTH  = 4;
    localparam int FIFO_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W  = FIFO_PTR_W + 1;

    localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (addr < DEPTH_LIMIT);
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request buffer of cmd_t records; a pop of an empty FIFO or a push
// into a full FIFO is ignored, so simultaneous push/pop keeps the count.
module mem_req_fifo
    import mem_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  cmd_t                  wr_cmd,
    output cmd_t                  rd_cmd,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    cmd_t                  slots_r [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wptr_r;
    logic [FIFO_PTR_W-1:0] rptr_r;
    logic [FIFO_CNT_W-1:0] cnt_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full      = (cnt_r == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty     = (cnt_r == {FIFO_CNT_W{1'b0}});
    assign count     = cnt_r;
    assign rd_cmd    = slots_r[rptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= {FIFO_PTR_W{1'b0}};
            rptr_r <= {FIFO_PTR_W{1'b0}};
            cnt_r  <= {FIFO_CNT_W{1'b0}};
        end else begin
            if (do_push_s) wptr_r <= wptr_r + 1'b1;
            if (do_pop_s)  rptr_r <= rptr_r + 1'b1;
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Entry storage; stale contents are harmless once the pointers reset.
    always_ff @(posedge clk) begin
        if (do_push_s) slots_r[wptr_r] <= wr_cmd;
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Serialising front-end for the 1024x32 async-read data memory.
// Out-of-range rejection is built only when MEM_PORT_CTRL_BOUNDS_CHECK_EN is defined.
module mem_port_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t                state_r;
    state_t                state_next_s;
    cmd_t                  cmd_r;
    cmd_t                  req_cmd_s;
    cmd_t                  head_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  head_ok_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [FIFO_CNT_W-1:0] fifo_count_s;
    logic                  mem_wen_r;
    logic                  mem_ren_r;
    logic                  rsp_valid_r;
    logic                  rsp_we_r;
    logic [DATA_W-1:0]     rsp_rdata_r;

    assign req_cmd_s = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign req_ready = (fifo_count_s != FIFO_CNT_W'(FIFO_DEPTH));
    assign push_s    = req_valid && !fifo_full_s;

    mem_req_fifo u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push_s),
        .pop    (pop_s),
        .wr_cmd (req_cmd_s),
        .rd_cmd (head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s),
        .count  (fifo_count_s)
    );

`ifdef MEM_PORT_CTRL_BOUNDS_CHECK_EN
    logic cmd_ok_s;
    logic rsp_err_r;
    assign head_ok_s = addr_in_range(head_s.addr);
    assign cmd_ok_s  = addr_in_range(cmd_r.addr);
    assign rsp_err   = rsp_err_r;

    // Error flag of the response being issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_r <= 1'b0;
        end else if (state_r == ISSUE) begin
            rsp_err_r <= !cmd_ok_s;
        end else begin
            rsp_err_r <= rsp_err_r;
        end
    end
`else
    assign head_ok_s = 1'b1;
    assign rsp_err   = 1'b0;
`endif

    // Next state and FIFO pop; a pop always coincides with entering ISSUE.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: state_next_s = RESP;
            RESP: begin
                if (rsp_ready && !fifo_empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ISSUE;
                end else if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, command register, registered memory enables and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cmd_r       <= '0;
            mem_wen_r   <= 1'b0;
            mem_ren_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_we_r    <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            mem_wen_r <= pop_s && head_s.we && head_ok_s;
            mem_ren_r <= pop_s && !head_s.we && head_ok_s;
            if (pop_s) cmd_r <= head_s;
            if (state_r == ISSUE) begin
                rsp_valid_r <= 1'b1;
                rsp_we_r    <= cmd_r.we;
                rsp_rdata_r <= mem_ren_r ? mem_rdata : {DATA_W{1'b0}};
            end else if (state_r == RESP && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
        end
    end

    assign mem_waddr = cmd_r.addr;
    assign mem_raddr = cmd_r.addr;
    assign mem_wdata = cmd_r.wdata;
    assign mem_wen   = mem_wen_r;
    assign mem_ren   = mem_ren_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_we    = rsp_we_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: directed timing/ordering cases plus randomized
// traffic, checked against an in-order transaction model of the memory.
module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_we;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_waddr;
    logic [31:0] mem_raddr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_port_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_waddr (mem_waddr),
        .mem_raddr (mem_raddr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata)
    );

    // Environment memory: synchronous write, combinational read, garbage when not enabled.
    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (mem_wen && mem_waddr < 32'd1024) ram[mem_waddr[9:0]] <= mem_wdata;
    end
    assign mem_rdata = (mem_ren && mem_raddr < 32'd1024) ? ram[mem_raddr[9:0]] : 32'hBAD0_BAD0;

    // Reference model: commands take effect in acceptance order.
    typedef struct { logic we; logic [31:0] rdata; logic err; } exp_rsp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } exp_iss_t;
    exp_rsp_t    exp_q [$];
    exp_iss_t    iss_q [$];
    logic [31:0] model_mem [1024];
    exp_rsp_t    cur_rsp;
    exp_iss_t    cur_iss;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic model_accept(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic err;
        err = 1'b0;
`ifdef MEM_PORT_CTRL_BOUNDS_CHECK_EN
        err = (a >= 32'd1024);
`endif
        if (err) begin
            exp_q.push_back('{we, 32'd0, 1'b1});
        end else if (we) begin
            model_mem[a[9:0]] = d;
            exp_q.push_back('{1'b1, 32'd0, 1'b0});
            iss_q.push_back('{1'b1, a, d});
        end else begin
            exp_q.push_back('{1'b0, model_mem[a[9:0]], 1'b0});
            iss_q.push_back('{1'b0, a, 32'd0});
        end
    endtask

    // Compare process: memory issues and response handshakes versus the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wen || mem_ren) begin
                check("en_exclusive", 64'(mem_wen & mem_ren), 64'd0);
                if (iss_q.size() == 0) begin
                    check("issue_expected", 64'(iss_q.size()), 64'd1);
                end else begin
                    cur_iss = iss_q.pop_front();
                    check("issue_we", 64'(mem_wen), 64'(cur_iss.we));
                    if (cur_iss.we) begin
                        check("issue_waddr", 64'(mem_waddr), 64'(cur_iss.addr));
                        check("issue_wdata", 64'(mem_wdata), 64'(cur_iss.wdata));
                    end else begin
                        check("issue_raddr", 64'(mem_raddr), 64'(cur_iss.addr));
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_expected", 64'(exp_q.size()), 64'd1);
                end else begin
                    cur_rsp = exp_q.pop_front();
                    check("rsp_we", 64'(rsp_we), 64'(cur_rsp.we));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(cur_rsp.rdata));
                    check("rsp_err", 64'(rsp_err), 64'(cur_rsp.err));
                end
            end
            if (req_valid && req_ready) model_accept(req_we, req_addr, req_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        step();
        exp_q.delete();
        iss_q.delete();
        for (int i = 0; i < 1024; i++) model_mem[i] = ram[i];
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_mem_wen"}, 64'(mem_wen), 64'd0);
        check({tag, "_mem_ren"}, 64'(mem_ren), 64'd0);
        check({tag, "_rsp_we"}, 64'(rsp_we), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 100; n++) begin
            if (exp_q.size() == 0 && !rsp_valid) break;
            step();
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        step();
    endtask

    // Single command on an idle block with rsp_ready high; checks cycle-exact timing.
    task automatic timed(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input string tag);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        check({tag, "_valid_n1"}, 64'(rsp_valid), 64'd0);
        check({tag, "_noissue_n1"}, 64'(mem_wen | mem_ren), 64'd0);
        step();
        check({tag, "_en_n2"}, 64'(we ? mem_wen : mem_ren), 64'd1);
        check({tag, "_addr_n2"}, 64'(we ? mem_waddr : mem_raddr), 64'(a));
        check({tag, "_valid_n2"}, 64'(rsp_valid), 64'd0);
        step();
        check({tag, "_valid_n3"}, 64'(rsp_valid), 64'd1);
        check({tag, "_we"}, 64'(rsp_we), 64'(we));
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
        check({tag, "_err"}, 64'(rsp_err), 64'd0);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 32'($urandom_range(0, 7));
`ifdef MEM_PORT_CTRL_BOUNDS_CHECK_EN
        if (r == 9) return 32'd1024 + 32'($urandom_range(0, 3));
`endif
        return 32'($urandom_range(1016, 1023));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int first;
        int second;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h1000_0000 + 32'(i);
        apply_reset();
        check_reset_state("reset");

        timed(1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, "wr5");
        wait_idle("wr5");
        timed(1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, "rd5");
        wait_idle("rd5");

        // Backpressure: FIFO plus one in flight, then req_ready drops.
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 32'(10 + i); req_wdata = 32'd0;
            if (req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        check("bp_accepted", 64'(acc), 64'd5);
        step();
        step();
        check("bp_ready_low", 64'(req_ready), 64'd0);
        check("bp_rsp_held", 64'(rsp_valid), 64'd1);
        check("bp_held_rdata", 64'(rsp_rdata), 64'h1000_000A);
        rsp_ready = 1'b1;
        wait_idle("bp");

        // Back-to-back write/read at the top address.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd1023; req_wdata = 32'hA5A5_0FF0;
        step();
        req_we = 1'b0; req_wdata = 32'd0;
        step();
        req_valid = 1'b0;
        first = -1;
        second = -1;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid) begin
                if (first < 0) begin
                    first = c;
                    check("b2b_wr_we", 64'(rsp_we), 64'd1);
                end else if (second < 0) begin
                    second = c;
                    check("b2b_rd_data", 64'(rsp_rdata), 64'hA5A5_0FF0);
                end
            end
            step();
        end
        check("b2b_spacing", 64'(second - first), 64'd2);
        wait_idle("b2b");

`ifdef MEM_PORT_CTRL_BOUNDS_CHECK_EN
        begin
            logic saw_wen;
            logic got;
            saw_wen = 1'b0;
            got = 1'b0;
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd1024; req_wdata = 32'h5555_AAAA;
            step();
            req_valid = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (mem_wen) saw_wen = 1'b1;
                if (rsp_valid && !got) begin
                    got = 1'b1;
                    check("oor_err", 64'(rsp_err), 64'd1);
                    check("oor_rdata", 64'(rsp_rdata), 64'd0);
                end
                step();
            end
            check("oor_no_wen", 64'(saw_wen), 64'd0);
            check("oor_got_rsp", 64'(got), 64'd1);
            wait_idle("oor");
            timed(1'b0, 32'd0, 32'd0, 32'h1000_0000, "oor_next");
            wait_idle("oor_next");
        end
`endif

        // Reset during a write's ISSUE cycle must suppress the write.
        timed(1'b1, 32'd9, 32'h1111_1111, 32'd0, "pre_rst");
        wait_idle("pre_rst");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd9; req_wdata = 32'h2222_2222;
        step();
        req_valid = 1'b0;
        step();
        check("rst_wen_before", 64'(mem_wen), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_wen_drop", 64'(mem_wen), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd1);
        apply_reset();
        check_reset_state("midrst");
        timed(1'b0, 32'd9, 32'd0, 32'h1111_1111, "post_rst");
        wait_idle("post_rst");

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_we    = ($urandom_range(0, 1) == 1);
            req_addr  = pick_addr();
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("random");
        check("random_issue_drained", 64'(iss_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
